// File: rtl/rotary_pkg.sv
// Shared quadrature definitions for the rotary source and decoder.
// Both ends take their direction convention from rot_next_phase().
package rotary_pkg;

    localparam logic ROT_CW  = 1'b1;
    localparam logic ROT_CCW = 1'b0;

    typedef logic [1:0] rot_phase_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_DWELL  = 2'd2
    } rqg_state_t;

    // Clockwise walks 00 -> 01 -> 11 -> 10 -> 00
    function automatic rot_phase_t rot_next_phase(
        input rot_phase_t phase,
        input logic       dir
    );
        rot_phase_t nxt;
        unique case (phase)
            2'b00:   nxt = (dir == ROT_CW) ? 2'b01 : 2'b10;
            2'b01:   nxt = (dir == ROT_CW) ? 2'b11 : 2'b00;
            2'b11:   nxt = (dir == ROT_CW) ? 2'b10 : 2'b01;
            default: nxt = (dir == ROT_CW) ? 2'b00 : 2'b11;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rotary_quad_gen_if.sv
// Step command handshake into the synthetic quadrature source.
// The master offers a direction, the generator takes it when idle.
interface rotary_quad_gen_if;

    logic step_valid;
    logic step_dir;
    logic step_ready;

    modport master (
        output step_valid,
        output step_dir,
        input  step_ready
    );

    modport slave (
        input  step_valid,
        input  step_dir,
        output step_ready
    );

endinterface

// File: rtl/rotary_quad_gen.sv
// Synthetic rotary dial: turns step commands into Gray-coded A/B
// phases with a programmable dwell and optional contact bounce.
module rotary_quad_gen
    import rotary_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES    = 1000,
    parameter int unsigned STEPS_PER_EVENT = 4,
    parameter int unsigned BOUNCE_PULSES   = 0
) (
    input  logic               clk,
    input  logic               reset,
    rotary_quad_gen_if.slave   step,
    output rot_phase_t         rotary_out,
    output logic               busy,
    output logic [15:0]        event_count
);

    localparam logic [15:0] DWELL_LD   = 16'(DWELL_CYCLES);
    localparam logic [3:0]  EDGE_LD    = 4'(STEPS_PER_EVENT);
    localparam logic [2:0]  BNC_LD     = 3'(BOUNCE_PULSES);
    localparam bit          HAS_BOUNCE = (BOUNCE_PULSES != 0);

    rqg_state_t  state_q, state_d;
    rot_phase_t  phase_q, phase_d;
    rot_phase_t  out_q, out_d;
    logic        dir_q, dir_d;
    logic [15:0] dwell_q, dwell_d;
    logic [3:0]  edge_q, edge_d;
    logic [2:0]  bnc_q, bnc_d;
    logic        glitch_q, glitch_d;
    logic        ready_q, ready_d;
    logic [15:0] event_count_q, event_count_d;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        out_d         = out_q;
        dir_d         = dir_q;
        dwell_d       = dwell_q;
        edge_d        = edge_q;
        bnc_d         = bnc_q;
        glitch_d      = glitch_q;
        event_count_d = event_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (step.step_valid && ready_q) begin
                    dir_d   = step.step_dir;
                    edge_d  = EDGE_LD;
                    phase_d = rot_next_phase(phase_q, step.step_dir);
                    out_d   = phase_d;
                    if (HAS_BOUNCE) begin
                        state_d  = ST_BOUNCE;
                        bnc_d    = BNC_LD;
                        glitch_d = 1'b0;
                    end else begin
                        state_d = ST_DWELL;
                        dwell_d = DWELL_LD;
                    end
                end
            end
            ST_BOUNCE: begin
                // phase_q is the new code; the glitch shows the old one
                if (!glitch_q) begin
                    out_d    = rot_next_phase(phase_q, ~dir_q);
                    glitch_d = 1'b1;
                end else begin
                    out_d    = phase_q;
                    glitch_d = 1'b0;
                    bnc_d    = bnc_q - 3'd1;
                    if (bnc_q == 3'd1) begin
                        state_d = ST_DWELL;
                        dwell_d = DWELL_LD;
                    end
                end
            end
            ST_DWELL: begin
                if (dwell_q == 16'd1) begin
                    edge_d = edge_q - 4'd1;
                    if (edge_q == 4'd1) begin
                        state_d       = ST_IDLE;
                        event_count_d = event_count_q + 16'd1;
                    end else begin
                        phase_d = rot_next_phase(phase_q, dir_q);
                        out_d   = phase_d;
                        if (HAS_BOUNCE) begin
                            state_d  = ST_BOUNCE;
                            bnc_d    = BNC_LD;
                            glitch_d = 1'b0;
                        end else begin
                            state_d = ST_DWELL;
                            dwell_d = DWELL_LD;
                        end
                    end
                end else begin
                    dwell_d = dwell_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= 2'b00;
            out_q         <= 2'b00;
            dir_q         <= 1'b0;
            dwell_q       <= 16'd0;
            edge_q        <= 4'd0;
            bnc_q         <= 3'd0;
            glitch_q      <= 1'b0;
            ready_q       <= 1'b1;
            event_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            out_q         <= out_d;
            dir_q         <= dir_d;
            dwell_q       <= dwell_d;
            edge_q        <= edge_d;
            bnc_q         <= bnc_d;
            glitch_q      <= glitch_d;
            ready_q       <= ready_d;
            event_count_q <= event_count_d;
        end
    end

    assign step.step_ready = ready_q;
    assign busy            = ~ready_q;
    assign rotary_out      = out_q;
    assign event_count     = event_count_q;

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Directed plus randomized bench for rotary_quad_gen, checked
// against a phase-index model and a transition-counting decoder.
module tb_rotary_quad_gen;
    import rotary_pkg::*;

    localparam int S1 = 4;
    localparam int D1 = 3;
    localparam int P1 = D1;
    localparam int S2 = 1;
    localparam int D2 = 3;
    localparam int B2 = 2;
    localparam int P2 = 2 * B2 + D2;

    logic        clk = 1'b0;
    logic        reset;
    rot_phase_t  rot1, rot2;
    logic        busy1, busy2;
    logic [15:0] cnt1, cnt2;

    rotary_quad_gen_if s1();
    rotary_quad_gen_if s2();

    rotary_quad_gen #(
        .DWELL_CYCLES(D1),
        .STEPS_PER_EVENT(S1),
        .BOUNCE_PULSES(0)
    ) dut1 (
        .clk(clk),
        .reset(reset),
        .step(s1),
        .rotary_out(rot1),
        .busy(busy1),
        .event_count(cnt1)
    );

    rotary_quad_gen #(
        .DWELL_CYCLES(D2),
        .STEPS_PER_EVENT(S2),
        .BOUNCE_PULSES(B2)
    ) dut2 (
        .clk(clk),
        .reset(reset),
        .step(s2),
        .rotary_out(rot2),
        .busy(busy2),
        .event_count(cnt2)
    );

    always #5 clk = ~clk;

    rot_phase_t gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    int          n_asrt = 0;
    int          n_fail = 0;
    int          mp     = 0;
    logic [15:0] mcount = 16'd0;

    function automatic int wrap4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    function automatic int pidx(input rot_phase_t v);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++)
            if (gray[i] == v) r = i;
        return r;
    endfunction

    // Independent decoder: counts single quarter-steps each way
    int         mon_cw   = 0;
    int         mon_ccw  = 0;
    rot_phase_t mon_prev = 2'b00;

    always @(negedge clk) begin
        mon_prev <= rot1;
        if (rot1 == gray[wrap4(pidx(mon_prev) + 1)])
            mon_cw <= mon_cw + 1;
        else if (rot1 == gray[wrap4(pidx(mon_prev) - 1)])
            mon_ccw <= mon_ccw + 1;
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_rdy", 32'(s1.step_ready), 32'd1);
            chk("idle_code", 32'(rot1), 32'(gray[mp]));
            cyc();
        end
    endtask

    task automatic run_cmd(input logic dir, input bit noisy);
        int tgt;
        chk("pre_rdy", 32'(s1.step_ready), 32'd1);
        s1.step_valid = 1'b1;
        s1.step_dir   = dir;
        cyc();
        s1.step_valid = 1'b0;
        for (int j = 0; j < S1; j++) begin
            tgt = wrap4(dir ? mp + j + 1 : mp - j - 1);
            for (int c = 0; c < P1; c++) begin
                chk("code", 32'(rot1), 32'(gray[tgt]));
                chk("busy_rdy", 32'(s1.step_ready), 32'd0);
                chk("busy", 32'(busy1), 32'd1);
                if (noisy) begin
                    s1.step_valid = 1'($urandom);
                    s1.step_dir   = 1'($urandom);
                end
                cyc();
            end
        end
        s1.step_valid = 1'b0;
        mp     = wrap4(dir ? mp + S1 : mp - S1);
        mcount = mcount + 16'd1;
        chk("post_rdy", 32'(s1.step_ready), 32'd1);
        chk("post_busy", 32'(busy1), 32'd0);
        chk("post_cnt", 32'(cnt1), 32'(mcount));
        chk("post_code", 32'(rot1), 32'(gray[mp]));
    endtask

    initial begin
        int    acc;
        int    acc_t [3];
        bit    rb;
        int    cw0, ccw0;
        int    p2;
        int    exp2;
        logic  d2;
        logic  rdir;

        reset         = 1'b1;
        s1.step_valid = 1'b0;
        s1.step_dir   = 1'b0;
        s2.step_valid = 1'b0;
        s2.step_dir   = 1'b0;
        cyc();
        cyc();
        chk("rst_code", 32'(rot1), 32'd0);
        chk("rst_rdy", 32'(s1.step_ready), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_code2", 32'(rot2), 32'd0);
        reset = 1'b0;
        cyc();

        // Bounce instance: one CW edge, then one CCW edge back
        p2 = 0;
        for (int k = 0; k < 2; k++) begin
            d2 = (k == 0) ? ROT_CW : ROT_CCW;
            s2.step_valid = 1'b1;
            s2.step_dir   = d2;
            cyc();
            s2.step_valid = 1'b0;
            for (int c = 0; c < P2; c++) begin
                if (c < 2 * B2 && (c % 2) == 1)
                    exp2 = p2;
                else
                    exp2 = wrap4(d2 ? p2 + 1 : p2 - 1);
                chk("bnc_code", 32'(rot2), 32'(gray[exp2]));
                chk("bnc_rdy", 32'(s2.step_ready), 32'd0);
                cyc();
            end
            p2 = wrap4(d2 ? p2 + 1 : p2 - 1);
            chk("bnc_done_rdy", 32'(s2.step_ready), 32'd1);
            chk("bnc_cnt", 32'(cnt2), 32'(k + 1));
            chk("bnc_hold", 32'(rot2), 32'(gray[p2]));
        end

        // Reset in the middle of a dwell while a request is pending
        s1.step_valid = 1'b1;
        s1.step_dir   = ROT_CW;
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        chk("mid_busy", 32'(busy1), 32'd1);
        reset = 1'b1;
        cyc();
        chk("mid_code", 32'(rot1), 32'd0);
        chk("mid_rdy", 32'(s1.step_ready), 32'd1);
        chk("mid_busy0", 32'(busy1), 32'd0);
        chk("mid_cnt", 32'(cnt1), 32'(mcount));
        reset         = 1'b0;
        s1.step_valid = 1'b0;
        mp = 0;
        idle1(2);

        // Loopback: 10 CW then 3 CCW detents
        cw0  = mon_cw;
        ccw0 = mon_ccw;
        run_cmd(ROT_CW, 1'b0);
        for (int i = 0; i < 9; i++) begin
            run_cmd(ROT_CW, 1'b1);
            idle1(int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 3; i++) begin
            run_cmd(ROT_CCW, 1'b1);
            idle1(int'($urandom_range(0, 3)));
        end
        cyc();
        chk("loop_cw", (mon_cw - cw0) / 4, 32'd10);
        chk("loop_ccw", (mon_ccw - ccw0) / 4, 32'd3);
        chk("loop_frac", ((mon_cw - cw0) % 4) + ((mon_ccw - ccw0) % 4), 32'd0);
        chk("loop_cnt", 32'(cnt1), 32'd13);

        // Held request: accepts spaced by one busy span plus the ready cycle
        acc = 0;
        s1.step_valid = 1'b1;
        s1.step_dir   = ROT_CW;
        for (int i = 0; i < 80 && acc < 3; i++) begin
            rb = s1.step_ready;
            cyc();
            if (rb && !s1.step_ready) begin
                acc_t[acc] = i;
                acc++;
                if (acc == 3) s1.step_valid = 1'b0;
            end
        end
        s1.step_valid = 1'b0;
        chk("held_acc", acc, 32'd3);
        if (acc == 3) begin
            chk("held_gap1", acc_t[1] - acc_t[0], S1 * P1 + 1);
            chk("held_gap2", acc_t[2] - acc_t[1], S1 * P1 + 1);
        end
        for (int i = 0; i < 40 && !s1.step_ready; i++) cyc();
        chk("held_done", 32'(s1.step_ready), 32'd1);
        mcount = mcount + 16'd3;
        chk("held_cnt", 32'(cnt1), 32'(mcount));
        chk("held_code", 32'(rot1), 32'(gray[mp]));

        // Random directions with noisy requests while busy
        for (int i = 0; i < 8; i++) begin
            rdir = 1'($urandom);
            run_cmd(rdir, 1'b1);
            idle1(int'($urandom_range(0, 2)));
        end

        // Counter wrap from 0xFFFF
        force dut1.event_count_q = 16'hFFFF;
        @(negedge clk);
        release dut1.event_count_q;
        cyc();
        mcount = 16'hFFFF;
        chk("wrap_pre", 32'(cnt1), 32'h0000FFFF);
        run_cmd(ROT_CCW, 1'b0);
        chk("wrap_zero", 32'(cnt1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
